// File: rtl/inst_fetch_queue_if.sv
// Bus bundle between the fetch stage, the instruction queue and the decode stage.
// master = fetch/decode side, slave = the queue itself.
interface inst_fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int IW    = 16,
   parameter int PW    = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   // Handshake: an entry moves fetch->queue on an edge where fetch_vld_in=1 and
   // full_out=0, and queue->decode on an edge where vld_out=1 and dec_rdy_in=1;
   // flush_in=1 overrides both transfers in that cycle.
   logic          fetch_vld_in;
   logic [IW-1:0] inst_in;
   logic [PW-1:0] pc_in;
   logic          full_out;
   logic          dec_rdy_in;
   logic          vld_out;
   logic [IW-1:0] inst_out;
   logic [PW-1:0] pc_out;
   logic [3:0]    opco_out;
   logic [1:0]    jmp_off_out;
   logic          flush_in;
   logic [CW-1:0] count_out;

   modport master (
      output fetch_vld_in, inst_in, pc_in, dec_rdy_in, flush_in,
      input  full_out, vld_out, inst_out, pc_out, opco_out, jmp_off_out, count_out
   );

   modport slave (
      input  fetch_vld_in, inst_in, pc_in, dec_rdy_in, flush_in,
      output full_out, vld_out, inst_out, pc_out, opco_out, jmp_off_out, count_out
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Zero-bubble instruction queue between fetch and decode, with redirect flush.
// Head entry is read combinationally from storage; occupancy is tracked explicitly.
module inst_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int IW    = 16,
   parameter int PW    = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   inst_fetch_queue_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [IW-1:0] r_mem_inst [DEPTH];
   logic [PW-1:0] r_mem_pc   [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_vld;
   logic w_push;
   logic w_pop;

   // full_out comes only from r_count, so dec_rdy_in never reaches it.
   assign w_full = (r_count == FULL_CNT);
   assign w_vld  = (r_count != '0);
   assign w_push = bus.fetch_vld_in & ~w_full & ~bus.flush_in;
   assign w_pop  = bus.dec_rdy_in & w_vld & ~bus.flush_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush_in) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_inst[r_wr_ptr] <= bus.inst_in;
         r_mem_pc[r_wr_ptr]   <= bus.pc_in;
      end
   end

   assign bus.full_out    = w_full;
   assign bus.vld_out     = w_vld;
   assign bus.count_out   = r_count;
   assign bus.inst_out    = r_mem_inst[r_rd_ptr];
   assign bus.pc_out      = r_mem_pc[r_rd_ptr];
   assign bus.opco_out    = r_mem_inst[r_rd_ptr][IW-1 -: 4];
   assign bus.jmp_off_out = r_mem_inst[r_rd_ptr][IW-5 -: 2];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: scoreboard queue of {inst, pc}
// updated at each edge, compared against the head outputs between edges.
module tb_inst_fetch_queue;
   localparam int DEPTH = 4;
   localparam int IW    = 16;
   localparam int PW    = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [IW+PW-1:0] exp_q[$];

   inst_fetch_queue_if #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) q_if ();

   inst_fetch_queue #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (q_if)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: hold inputs across one rising edge and update the scoreboard
   task automatic drive(input logic fv, input logic [IW-1:0] inst, input logic [PW-1:0] pc,
                        input logic dr, input logic fl);
      logic do_push;
      logic do_pop;
      q_if.fetch_vld_in = fv;
      q_if.inst_in      = inst;
      q_if.pc_in        = pc;
      q_if.dec_rdy_in   = dr;
      q_if.flush_in     = fl;
      @(posedge clk);
      do_push = fv && (exp_q.size() < DEPTH) && !fl;
      do_pop  = dr && (exp_q.size() != 0) && !fl;
      if (fl) exp_q.delete();
      else begin
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back({inst, pc});
      end
      #1;
      q_if.fetch_vld_in = 1'b0;
      q_if.dec_rdy_in   = 1'b0;
      q_if.flush_in     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      q_if.fetch_vld_in = 1'b0;
      q_if.inst_in = '0;
      q_if.pc_in = '0;
      q_if.dec_rdy_in = 1'b0;
      q_if.flush_in = 1'b0;
      exp_q.delete();
      #12;
      total++;
      if (q_if.vld_out !== 1'b0 || q_if.full_out !== 1'b0 || q_if.count_out !== '0) begin
         bad++;
         $display("FAIL reset: vld=%b full=%b count=%0d, required 0 0 0",
                  q_if.vld_out, q_if.full_out, q_if.count_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #4;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h1000 + 16'(i), 16'(i), 1'b0, 1'b0);
         total++;
         if (q_if.count_out !== CW'(i + 1)) begin
            bad++;
            $display("FAIL fill_count: count=%0d required=%0d", q_if.count_out, i + 1);
         end
      end
      total++;
      if (q_if.full_out !== 1'b1) begin
         bad++;
         $display("FAIL fill_full: full=%b required=1", q_if.full_out);
      end
      drive(1'b1, 16'h1004, 16'd4, 1'b0, 1'b0);
      total++;
      if (q_if.count_out !== CW'(4) || q_if.inst_out !== 16'h1000) begin
         bad++;
         $display("FAIL push_while_full: count=%0d head=%h required 4 1000",
                  q_if.count_out, q_if.inst_out);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (q_if.vld_out !== 1'b1 || q_if.inst_out !== 16'h1000 + 16'(i) ||
             q_if.pc_out !== 16'(i) || {q_if.inst_out, q_if.pc_out} !== exp_q[0]) begin
            bad++;
            $display("FAIL drain_order: vld=%b inst=%h pc=%h required 1 %h %h",
                     q_if.vld_out, q_if.inst_out, q_if.pc_out, 16'h1000 + 16'(i), 16'(i));
         end
         drive(1'b0, '0, '0, 1'b1, 1'b0);
      end
      total++;
      if (q_if.vld_out !== 1'b0 || q_if.count_out !== '0) begin
         bad++;
         $display("FAIL drain_empty: vld=%b count=%0d required 0 0", q_if.vld_out, q_if.count_out);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      total++;
      if (q_if.vld_out !== 1'b0 || q_if.count_out !== '0 || q_if.full_out !== 1'b0) begin
         bad++;
         $display("FAIL pop_while_empty: vld=%b count=%0d full=%b required 0 0 0",
                  q_if.vld_out, q_if.count_out, q_if.full_out);
      end
   endtask

   task automatic test_stream();
      logic [PW-1:0] pc;
      drive(1'b1, 16'h2000, 16'h0100, 1'b0, 1'b0);
      drive(1'b1, 16'h2001, 16'h0101, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         total++;
         if (q_if.vld_out !== 1'b1 || {q_if.inst_out, q_if.pc_out} !== exp_q[0]) begin
            bad++;
            $display("FAIL stream_head: vld=%b got=%h_%h required=%h",
                     q_if.vld_out, q_if.inst_out, q_if.pc_out, exp_q[0]);
         end
         pc = 16'h0102 + 16'(i);
         drive(1'b1, 16'h2002 + 16'(i), pc, 1'b1, 1'b0);
         total++;
         if (q_if.count_out !== CW'(2)) begin
            bad++;
            $display("FAIL stream_count: count=%0d required=2", q_if.count_out);
         end
      end
      // after 10 stream beats the head must be the 11th word pushed
      total++;
      if (q_if.inst_out !== 16'h200A || q_if.pc_out !== 16'h010A) begin
         bad++;
         $display("FAIL stream_wrap: head=%h pc=%h required 200a 010a", q_if.inst_out, q_if.pc_out);
      end
   endtask

   task automatic test_opcode();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      drive(1'b1, 16'hF800, 16'h0040, 1'b0, 1'b0);
      total++;
      if (q_if.opco_out !== 4'b1111 || q_if.jmp_off_out !== 2'b10) begin
         bad++;
         $display("FAIL opcode_f800: opco=%b jmp=%b required 1111 10", q_if.opco_out, q_if.jmp_off_out);
      end
      drive(1'b1, 16'h1234, 16'h0041, 1'b1, 1'b0);
      total++;
      if (q_if.opco_out !== 4'b0001 || q_if.jmp_off_out !== 2'b00 || q_if.inst_out !== 16'h1234) begin
         bad++;
         $display("FAIL opcode_1234: inst=%h opco=%b jmp=%b required 1234 0001 00",
                  q_if.inst_out, q_if.opco_out, q_if.jmp_off_out);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 16'(16'h3000 + $urandom_range(0, 255)), 16'(i + 'h200), 1'b0, 1'b0);
      end
      total++;
      if (q_if.count_out !== CW'(3)) begin
         bad++;
         $display("FAIL flush_pre: count=%0d required=3", q_if.count_out);
      end
      drive(1'b1, 16'hDEAD, 16'h0300, 1'b1, 1'b1);
      total++;
      if (q_if.count_out !== '0 || q_if.vld_out !== 1'b0) begin
         bad++;
         $display("FAIL flush_collision: count=%0d vld=%b required 0 0", q_if.count_out, q_if.vld_out);
      end
      drive(1'b1, 16'hC0AB, 16'h0301, 1'b0, 1'b0);
      total++;
      if (q_if.vld_out !== 1'b1 || q_if.inst_out !== 16'hC0AB || q_if.count_out !== CW'(1)) begin
         bad++;
         $display("FAIL flush_resume: vld=%b inst=%h count=%0d required 1 c0ab 1",
                  q_if.vld_out, q_if.inst_out, q_if.count_out);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 16'h4000, 16'h0400, 1'b0, 1'b0);
      total++;
      if (q_if.count_out !== CW'(2)) begin
         bad++;
         $display("FAIL areset_pre: count=%0d required=2", q_if.count_out);
      end
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      total++;
      if (q_if.vld_out !== 1'b0 || q_if.count_out !== '0 || q_if.full_out !== 1'b0) begin
         bad++;
         $display("FAIL areset_async: vld=%b count=%0d full=%b required 0 0 0",
                  q_if.vld_out, q_if.count_out, q_if.full_out);
      end
      rst_n = 1'b1;
      drive(1'b1, 16'h5A5A, 16'h0500, 1'b0, 1'b0);
      total++;
      if (q_if.vld_out !== 1'b1 || {q_if.inst_out, q_if.pc_out} !== exp_q[0] ||
          q_if.inst_out !== 16'h5A5A || q_if.count_out !== CW'(1)) begin
         bad++;
         $display("FAIL areset_resume: vld=%b inst=%h count=%0d required 1 5a5a 1",
                  q_if.vld_out, q_if.inst_out, q_if.count_out);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_opcode();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 Parameter IW, default 16, instruction width in bits.
REQ-003 Parameter PW, default 16, program-counter width in bits.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port fetch_vld_in, input, 1 bit: fetch stage presents an instruction this cycle.
REQ-008 Port inst_in, input, IW bits: fetched instruction word.
REQ-009 Port pc_in, input, PW bits: PC of inst_in.
REQ-010 Port full_out, output, 1 bit: queue cannot accept a push this cycle.
REQ-011 Port dec_rdy_in, input, 1 bit: decode stage consumes the head entry this cycle.
REQ-012 Port vld_out, output, 1 bit: the head entry is valid.
REQ-013 Port inst_out, output, IW bits: head instruction.
REQ-014 Port pc_out, output, PW bits: head PC.
REQ-015 Port opco_out, output, 4 bits: inst_out[IW-1:IW-4], the opcode fed to the control unit.
REQ-016 Port jmp_off_out, output, 2 bits: inst_out[IW-5:IW-6], the jump sub-op fed to the control unit.
REQ-017 Port flush_in, input, 1 bit: discard all queued entries (branch/jump redirect).
REQ-018 Port count_out, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-019 Storage: DEPTH entries of {inst, pc}; read pointer rd_ptr and write pointer wr_ptr are each log2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 Push condition: push = fetch_vld_in & ~full_out & ~flush_in; a push writes {inst_in, pc_in} at wr_ptr, then wr_ptr increments.
REQ-021 Pop condition: pop = dec_rdy_in & vld_out & ~flush_in; a pop increments rd_ptr.
REQ-022 full_out = (count == DEPTH); it depends only on registered state and SHALL have no combinational path from dec_rdy_in.
REQ-023 vld_out = (count != 0); inst_out, pc_out, opco_out and jmp_off_out present the entry at rd_ptr combinationally from storage.
REQ-024 Latency: an entry pushed at edge N is visible on the outputs after edge N (zero-bubble); back-to-back push and pop every cycle sustain one instruction per cycle.
REQ-025 Count update: count += push - pop; simultaneous push and pop leave count unchanged and advance both pointers.
REQ-026 Push while full: the push is ignored, and the upstream stage holds inst_in until full_out deasserts.
REQ-027 Pop while empty: dec_rdy_in with vld_out=0 has no effect; pointers and count do not move.
REQ-028 Flush: a flush at edge N sets rd_ptr = wr_ptr = 0 and count = 0, and vld_out = 0 after edge N; a push or pop in the same cycle is dropped; storage contents are don't-care.
REQ-029 Ordering: entries leave in strict FIFO order; an entry SHALL never be duplicated or lost except by flush.
REQ-030 When vld_out = 0, inst_out, pc_out, opco_out and jmp_off_out are don't-care, and the decoder SHALL ignore them.

Reset
REQ-031 Assertion of rst_n = 0 immediately (asynchronously) sets rd_ptr = 0, wr_ptr = 0 and count = 0, giving vld_out = 0, full_out = 0 and count_out = 0.
REQ-032 Storage arrays are not reset.
REQ-033 Reset mid-operation discards all entries exactly as a flush does.
REQ-034 The first push is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Fill to full: reset, then push 0x1000..0x1003 with PC 0..3 and dec_rdy_in=0 -> count_out 1,2,3,4; full_out=1 after the 4th edge; a 5th push of 0x1004 is ignored with count_out staying 4.
REQ-036 Drain in order: from the full state, dec_rdy_in=1 for 4 cycles -> inst_out shows 0x1000,0x1001,0x1002,0x1003 in sequence, then vld_out=0 and further pops have no effect.
REQ-037 Streaming wrap-around: simultaneous push and pop on every cycle for 10 cycles at count 2 -> count_out constant at 2, pointers wrap, and outputs match the push order with no bubble.
REQ-038 Opcode split: head inst 0xF800 -> opco_out=4'b1111 and jmp_off_out=2'b10; head inst 0x1234 -> opco_out=4'b0001 and jmp_off_out=2'b00.
REQ-039 Flush collision: count 3, with flush_in=1, fetch_vld_in=1 and dec_rdy_in=1 in the same cycle -> next cycle count_out=0 and vld_out=0; a subsequent push of 0xC0AB appears at the head one cycle later.
REQ-040 Asynchronous reset: pull rst_n low mid-cycle at count 2 -> vld_out=0 and count_out=0 before the next clock edge; normal operation resumes after release.
